// File: rtl/uarc_stream_sender.sv
// Byte-stream sender feeding a core0 UARC receiver port (send/data/send_ack), FIFO-buffered.
// Optional LF -> CR,LF expansion is enabled with `define UARC_STREAM_SENDER_CR_EXPAND_EN.
//
//   state      | meaning
//   ST_IDLE    | no word offered; bus_data holds the last word
//   ST_SEND    | word offered on bus_data, waiting for send_ack
//   ST_CR_PEND | 0x0D offered ahead of a popped 0x0A (expansion build only)
module uarc_stream_sender #(
  parameter int WORD_MAG        = 5,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  input  logic                               bus_enable,
  output logic                               bus_send,
  output logic [(1 << WORD_MAG)-1:0]         bus_data,
  input  logic                               bus_send_ack,
  output logic [FIFO_ADDR_WIDTH:0]           fifo_level,
  output logic [(1 << WORD_MAG)-1:0]         sent_count
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int DEPTH      = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0]   LVL_FULL = (FIFO_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0]   LVL_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);

`ifdef UARC_STREAM_SENDER_CR_EXPAND_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CR_PEND} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_t;
`endif

  state_t                     r_state;
  logic                       r_send;
  logic [7:0]                 r_byte;
  logic [WORD_WIDTH-1:0]      r_count;
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_level;

  logic       w_not_full;
  logic       w_not_empty;
  logic       w_push;
  logic       w_ack_done;
  logic       w_free;
  logic       w_pop;
  logic [7:0] w_head;
  logic [7:0] w_load_byte;
  state_t     w_load_state;

  assign w_not_full  = (r_level != LVL_FULL);
  assign w_not_empty = (r_level != '0);
  assign w_push      = in_valid && w_not_full;
  assign w_ack_done  = r_send && bus_send_ack;
  // The slot frees up in the same cycle the current word is acked, giving back-to-back words.
  assign w_free      = (r_state == ST_IDLE) || ((r_state == ST_SEND) && w_ack_done);
  assign w_pop       = w_free && w_not_empty && bus_enable;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_load_byte  = w_head;
    w_load_state = ST_SEND;
`ifdef UARC_STREAM_SENDER_CR_EXPAND_EN
    if (w_head == 8'h0A) begin
      w_load_byte  = 8'h0D;
      w_load_state = ST_CR_PEND;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_send  <= 1'b0;
      r_byte  <= 8'h00;
      r_count <= '0;
    end else begin
      if (w_ack_done) r_count <= r_count + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_byte  <= w_load_byte;
            r_state <= w_load_state;
            r_send  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_ack_done) begin
            if (w_pop) begin
              r_byte  <= w_load_byte;
              r_state <= w_load_state;
            end else begin
              r_state <= ST_IDLE;
              r_send  <= 1'b0;
            end
          end
        end
`ifdef UARC_STREAM_SENDER_CR_EXPAND_EN
        ST_CR_PEND: begin
          if (w_ack_done) begin
            r_byte  <= 8'h0A;
            r_state <= ST_SEND;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_send  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = w_not_full;
  assign bus_send   = r_send;
  assign bus_data   = {{(WORD_WIDTH-8){1'b0}}, r_byte};
  assign fifo_level = r_level;
  assign sent_count = r_count;

endmodule

// File: tb/tb_uarc_stream_sender.sv
// Randomized bench for uarc_stream_sender against a queue-based model of the byte stream.
// Define UARC_STREAM_SENDER_CR_EXPAND_EN for both DUT and bench to exercise LF expansion.
module tb_uarc_stream_sender;

  localparam int WORD_WIDTH = 32;
  localparam int DEPTH      = 16;
`ifdef UARC_STREAM_SENDER_CR_EXPAND_EN
  localparam bit CR_EN = 1'b1;
`else
  localparam bit CR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic                  in_ready;
  logic                  bus_enable = 1'b0;
  logic                  bus_send;
  logic [WORD_WIDTH-1:0] bus_data;
  logic                  bus_send_ack = 1'b0;
  logic [4:0]            fifo_level;
  logic [WORD_WIDTH-1:0] sent_count;

  int n_err = 0;
  int n_chk = 0;

  // Model: the buffered bytes, the word on the bus, and a pending LF behind an emitted CR.
  byte unsigned m_q[$];
  bit           m_send;
  byte unsigned m_data;
  bit           m_lf_pending;
  int unsigned  m_cnt;

  uarc_stream_sender #(.WORD_MAG(5), .FIFO_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bus_enable(bus_enable), .bus_send(bus_send), .bus_data(bus_data),
    .bus_send_ack(bus_send_ack), .fifo_level(fifo_level), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_send = 1'b0;
    m_data = 8'h00;
    m_lf_pending = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit accept;
    bit done;
    bit free;
    byte unsigned b;
    accept = in_valid && (m_q.size() != DEPTH);
    done   = m_send && bus_send_ack;
    if (done) m_cnt++;
    free = !m_send || (done && !m_lf_pending);
    if (done && m_lf_pending) begin
      m_data = 8'h0A;
      m_lf_pending = 1'b0;
    end else if (free && m_q.size() > 0 && bus_enable) begin
      b = m_q.pop_front();
      m_send = 1'b1;
      if (CR_EN && b == 8'h0A) begin
        m_data = 8'h0D;
        m_lf_pending = 1'b1;
      end else begin
        m_data = b;
      end
    end else if (free) begin
      m_send = 1'b0;
    end
    if (accept) m_q.push_back(in_data);
  endtask

  task automatic compare_all();
    check("bus_send",   64'(bus_send),   64'(m_send));
    check("bus_data",   64'(bus_data),   64'(m_data));
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("in_ready",   64'(in_ready),   64'(m_q.size() != DEPTH));
    check("sent_count", 64'(sent_count), 64'(m_cnt));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic en, input logic ak);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    bus_enable = en;
    bus_send_ack = ak;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_send",  64'(bus_send),   64'(0));
    check("rst_data",  64'(bus_data),   64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_count", 64'(sent_count), 64'(0));
    in_valid = 1'b0;
    bus_enable = 1'b0;
    bus_send_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b1;

    // Get a word onto the bus, then reset while it waits for ack.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_send", 64'(bus_send), 64'(1));
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // 'H' with ack four cycles after bus_send rises.
    step(1'b1, 8'h48, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("h_count", 64'(sent_count), 64'(1));
    check("h_data",  64'(bus_data),   64'(32'h48));

    // Fill with enable low, 17th push dropped, then drain with ack tied high.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_ready", 64'(in_ready), 64'(0));
    // Pop one at full while offering a push (refused at full), then push+pop at level 15.
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Enable dropped while a word awaits ack.
    step(1'b1, 8'h31, 1'b1, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // LF handling, then ack without a word on the bus.
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'(i % 2));
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with LF-heavy data.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = ($urandom_range(3) == 0) ? 8'h0A : 8'($urandom);
      step(1'($urandom_range(1)), d, ($urandom_range(3) != 0), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b1, 1'b1);

    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
